// File: rtl/err_bit_scan_ctrl_pkg.sv
// Shared types and width derivations for the error-bit scan sequencer.
// Segment width is tied to the 32-bit leading-zero counter.
package err_scan_pkg;

    localparam int SEG_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    function automatic int nseg_of(input int word_w);
        return word_w / SEG_W;
    endfunction

    function automatic int idx_w_of(input int word_w);
        return $clog2(word_w);
    endfunction

    // A single-segment word still needs a 1-bit pointer register.
    function automatic int ptr_w_of(input int word_w);
        return (word_w / SEG_W > 1) ? $clog2(word_w / SEG_W) : 1;
    endfunction

endpackage

// File: rtl/err_bit_scan_ctrl_cntlz32.sv
// Combinational 32-bit leading-zero counter.
// Returns 32 for an all-zero input.
module cntlz32 (
    input  logic [31:0] i_word,
    output logic [5:0]  o_lz
);

    always_comb begin
        o_lz = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i_word[i]) o_lz = 6'(31 - i);
        end
    end

endmodule

// File: rtl/err_bit_scan_ctrl.sv
// Converts an error-flag word into an MSB-first stream of set-bit indices,
// time-sharing one cntlz32 over the word's 32-bit segments.
module err_bit_scan_ctrl
    import err_scan_pkg::*;
#(
    parameter int WORD_W = 128,
    parameter int NSEG   = nseg_of(WORD_W),
    parameter int IDX_W  = idx_w_of(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_empty,
    output logic [IDX_W:0]    out_cnt,
    input  logic              flush
);

    localparam int PTR_W = ptr_w_of(WORD_W);
    localparam logic [PTR_W-1:0]  PTR_TOP = PTR_W'(NSEG - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [IDX_W:0]    CNT_ONE = (IDX_W + 1)'(1);
    localparam logic [WORD_W-1:0] BIT0    = WORD_W'(1);

    state_t r_state;
    state_t w_state_nxt;

    logic [WORD_W-1:0] r_shadow;
    logic [WORD_W-1:0] w_shadow_nxt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [IDX_W:0]    r_cnt;
    logic [IDX_W:0]    w_cnt_nxt;

    logic              r_valid;
    logic              w_valid_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic              r_empty;
    logic              w_empty_nxt;
    logic [IDX_W:0]    r_ocnt;
    logic [IDX_W:0]    w_ocnt_nxt;

    logic [SEG_W-1:0]  w_seg;
    logic [5:0]        w_lz;
    logic              w_seg_zero;
    logic [IDX_W-1:0]  w_bit;
    logic [WORD_W-1:0] w_cleared;
    logic              w_shadow_zero;

    always_comb begin
        w_seg = '0;
        for (int s = 0; s < NSEG; s++) begin
            if (r_ptr == PTR_W'(s)) w_seg = r_shadow[s*SEG_W +: SEG_W];
        end
    end

    cntlz32 u_lz (
        .i_word (w_seg),
        .o_lz   (w_lz)
    );

    // lz==32 flags an empty segment; otherwise 31-lz is ~lz[4:0].
    assign w_seg_zero    = w_lz[5];
    assign w_bit         = IDX_W'({r_ptr, ~w_lz[4:0]});
    assign w_cleared     = r_shadow & ~(BIT0 << w_bit);
    assign w_shadow_zero = ~|r_shadow;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign out_empty = r_empty;
    assign out_cnt   = r_ocnt;

    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_valid_nxt  = r_valid;
        w_idx_nxt    = r_idx;
        w_last_nxt   = r_last;
        w_empty_nxt  = r_empty;
        w_ocnt_nxt   = r_ocnt;
        if (flush) begin
            w_state_nxt  = IDLE;
            w_shadow_nxt = '0;
            w_ptr_nxt    = PTR_TOP;
            w_cnt_nxt    = '0;
            w_valid_nxt  = 1'b0;
            w_idx_nxt    = '0;
            w_last_nxt   = 1'b0;
            w_empty_nxt  = 1'b0;
            w_ocnt_nxt   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        w_shadow_nxt = in_word;
                        w_ptr_nxt    = PTR_TOP;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = SCAN;
                    end
                end
                SCAN: begin
                    if (w_shadow_zero && (r_cnt == '0)) begin
                        w_valid_nxt = 1'b1;
                        w_idx_nxt   = '0;
                        w_last_nxt  = 1'b1;
                        w_empty_nxt = 1'b1;
                        w_ocnt_nxt  = '0;
                        w_state_nxt = EMIT;
                    end else if (w_seg_zero) begin
                        w_ptr_nxt = r_ptr - PTR_ONE;
                    end else begin
                        w_valid_nxt  = 1'b1;
                        w_idx_nxt    = w_bit;
                        w_last_nxt   = ~|w_cleared;
                        w_empty_nxt  = 1'b0;
                        w_ocnt_nxt   = r_cnt + CNT_ONE;
                        w_cnt_nxt    = r_cnt + CNT_ONE;
                        w_shadow_nxt = w_cleared;
                        w_state_nxt  = EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = r_last ? IDLE : SCAN;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_ptr    <= PTR_TOP;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_last   <= 1'b0;
            r_empty  <= 1'b0;
            r_ocnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_valid_nxt;
            r_idx    <= w_idx_nxt;
            r_last   <= w_last_nxt;
            r_empty  <= w_empty_nxt;
            r_ocnt   <= w_ocnt_nxt;
        end
    end

endmodule
